dac_soft_mute: RTL and testbench

//  Output conditioning stage between the RX DSP core's real DAC bus (concat_real_dacN) and the RF-DAC data port.
//  - Applies a linear soft-mute ramp (gain 0 -> 1.0 -> 0) so DAC enable/disable never produces a step.
//  - Applies a static power-of-two output boost with saturation.
//  - One instance per DAC channel (dac1/dac2/dac3).
//  - All NUMBER_OF_LINE lanes are parallel samples of one stream and share one gain value per cycle.

---
 rtl/dac_soft_mute.sv | 146 ++++++++++++++
 tb/tb_dac_soft_mute.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dac_soft_mute.sv
// dac_soft_mute: linear soft-mute gain ramp plus power-of-two boost with saturation, 2-clock datapath.
// Optional clip counter enabled by defining DAC_SOFT_MUTE_CLIP_COUNT_EN.
`default_nettype none

module dac_soft_mute #(
   parameter int NUMBER_OF_LINE = 8
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [15:0]                 ramp_step,
   input  logic [1:0]                  gain_shift,
   input  logic [16*NUMBER_OF_LINE-1:0] dac_in,
   output logic [16*NUMBER_OF_LINE-1:0] dac_out,
   output logic [16:0]                 ramp_gain,
   output logic [1:0]                  state,
   output logic                        ramp_done,
   output logic [15:0]                 clip_count
);

   localparam logic [1:0]  S_IDLE      = 2'd0;
   localparam logic [1:0]  S_RAMP_UP   = 2'd1;
   localparam logic [1:0]  S_ACTIVE    = 2'd2;
   localparam logic [1:0]  S_RAMP_DOWN = 2'd3;
   localparam logic [17:0] UNITY       = 18'd32768;

   logic [1:0]  state_nxt;
   logic [16:0] gain_nxt;
   logic        done_nxt;
   logic        go_up;
   logic        go_down;
   logic [17:0] gain_ext;
   logic [17:0] step_ext;
   logic [17:0] gain_sum;
   logic [16:0] gain_diff;

   assign gain_ext  = {1'b0, ramp_gain};
   assign step_ext  = {2'b00, ramp_step};
   assign gain_sum  = gain_ext + step_ext;
   assign gain_diff = ramp_gain - {1'b0, ramp_step};

   // A direction reversal holds g for that clock; only steps toward the target move it.
   always_comb begin
      state_nxt = state;
      gain_nxt  = ramp_gain;
      done_nxt  = 1'b0;
      go_up     = 1'b0;
      go_down   = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) go_up = 1'b1;
            else        gain_nxt = '0;
         end
         S_RAMP_UP: begin
            if (!enable) state_nxt = S_RAMP_DOWN;
            else         go_up = 1'b1;
         end
         S_ACTIVE: begin
            if (!enable) go_down = 1'b1;
            else         gain_nxt = UNITY[16:0];
         end
         default: begin
            if (enable) state_nxt = S_RAMP_UP;
            else        go_down = 1'b1;
         end
      endcase
      if (go_up) begin
         if (ramp_step == 16'd0 || gain_sum >= UNITY) begin
            state_nxt = S_ACTIVE;
            gain_nxt  = UNITY[16:0];
            done_nxt  = 1'b1;
         end else begin
            state_nxt = S_RAMP_UP;
            gain_nxt  = gain_sum[16:0];
         end
      end
      if (go_down) begin
         if (ramp_step == 16'd0 || gain_ext <= step_ext) begin
            state_nxt = S_IDLE;
            gain_nxt  = '0;
            done_nxt  = 1'b1;
         end else begin
            state_nxt = S_RAMP_DOWN;
            gain_nxt  = gain_diff;
         end
      end
   end

   logic signed [33:0]            prod_nxt [NUMBER_OF_LINE];
   logic signed [33:0]            prod     [NUMBER_OF_LINE];
   logic [1:0]                    shift_s1;
   logic [16*NUMBER_OF_LINE-1:0]  sat_vec;
`ifdef DAC_SOFT_MUTE_CLIP_COUNT_EN
   logic [NUMBER_OF_LINE-1:0]     clip_lane;
`endif

   for (genvar k = 0; k < NUMBER_OF_LINE; k++) begin : g_lane
      logic signed [36:0] rnd;
      logic signed [36:0] boosted;
      logic               over;
      logic               under;

      assign prod_nxt[k] = $signed({{18{dac_in[16*k+15]}}, dac_in[16*k +: 16]})
                         * $signed({17'd0, ramp_gain});
      // Adding half an LSB before the arithmetic shift rounds half up.
      assign rnd     = ($signed({{3{prod[k][33]}}, prod[k]}) + 37'sd16384) >>> 15;
      assign boosted = rnd <<< shift_s1;
      assign over    = boosted > 37'sd32767;
      assign under   = boosted < -37'sd32768;
      assign sat_vec[16*k +: 16] = over  ? 16'h7FFF :
                                   under ? 16'h8000 : boosted[15:0];
`ifdef DAC_SOFT_MUTE_CLIP_COUNT_EN
      assign clip_lane[k] = over | under;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         ramp_gain <= '0;
         ramp_done <= 1'b0;
         shift_s1  <= '0;
         dac_out   <= '0;
         for (int k = 0; k < NUMBER_OF_LINE; k++) prod[k] <= '0;
      end else begin
         state     <= state_nxt;
         ramp_gain <= gain_nxt;
         ramp_done <= done_nxt;
         shift_s1  <= gain_shift;
         dac_out   <= sat_vec;
         for (int k = 0; k < NUMBER_OF_LINE; k++) prod[k] <= prod_nxt[k];
      end
   end

`ifdef DAC_SOFT_MUTE_CLIP_COUNT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                                    clip_count <= '0;
      else if ((|clip_lane) && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
   end
`else
   assign clip_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dac_soft_mute.sv
// tb_dac_soft_mute: directed stimulus against an arithmetic reference model, checked every clock.
`default_nettype none

module tb_dac_soft_mute;

   localparam int N = 8;

   logic             clock = 1'b0;
   logic             reset;
   logic             enable;
   logic [15:0]      ramp_step;
   logic [1:0]       gain_shift;
   logic [16*N-1:0]  dac_in;
   logic [16*N-1:0]  dac_out;
   logic [16:0]      ramp_gain;
   logic [1:0]       state;
   logic             ramp_done;
   logic [15:0]      clip_count;

   int checks = 0;
   int errors = 0;

   dac_soft_mute #(.NUMBER_OF_LINE(N)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .ramp_step  (ramp_step),
      .gain_shift (gain_shift),
      .dac_in     (dac_in),
      .dac_out    (dac_out),
      .ramp_gain  (ramp_gain),
      .state      (state),
      .ramp_done  (ramp_done),
      .clip_count (clip_count)
   );

   always #5 clock = ~clock;

   // Reference model: gain law in plain integers, datapath as a two-deep queue of expected words.
   int              m_state = 0;
   int              m_g = 0;
   int              m_done = 0;
   int              m_clip_cnt = 0;
   logic [16*N-1:0] m_s1_out = '0;
   logic [16*N-1:0] m_out = '0;
   bit              m_s1_clip = 0;
   longint          mx, mr, ms;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_state = 0; m_g = 0; m_done = 0; m_clip_cnt = 0;
         m_s1_out = '0; m_out = '0; m_s1_clip = 0;
      end else begin
         m_out = m_s1_out;
`ifdef DAC_SOFT_MUTE_CLIP_COUNT_EN
         if (m_s1_clip && m_clip_cnt < 65535) m_clip_cnt++;
`endif
         m_s1_clip = 0;
         for (int k = 0; k < N; k++) begin
            mx = $signed(dac_in[16*k +: 16]);
            mr = (mx * m_g + 16384) >>> 15;
            ms = mr * (64'sd1 << gain_shift);
            if (ms > 32767)       begin m_s1_out[16*k +: 16] = 16'h7FFF; m_s1_clip = 1; end
            else if (ms < -32768) begin m_s1_out[16*k +: 16] = 16'h8000; m_s1_clip = 1; end
            else                  m_s1_out[16*k +: 16] = 16'(ms);
         end
         m_done = 0;
         if (m_state == 1 && !enable)      m_state = 3;
         else if (m_state == 3 && enable)  m_state = 1;
         else if (enable && m_state != 2) begin
            if (ramp_step == 0 || m_g + ramp_step >= 32768) begin
               m_g = 32768; m_state = 2; m_done = 1;
            end else begin
               m_g = m_g + ramp_step; m_state = 1;
            end
         end else if (!enable && m_state != 0) begin
            if (ramp_step == 0 || m_g <= ramp_step) begin
               m_g = 0; m_state = 0; m_done = 1;
            end else begin
               m_g = m_g - ramp_step; m_state = 3;
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         checks++;
         if (dac_out !== m_out) begin
            errors++;
            $display("FAIL model dac_out: got %h, expected %h at %0t", dac_out, m_out, $time);
         end
         chk("model ramp_gain", ramp_gain, m_g);
         chk("model state", state, m_state);
         chk("model ramp_done", ramp_done, m_done);
         chk("model clip_count", clip_count, m_clip_cnt);
      end
   end

   function automatic int lane(input int k);
      return $signed(dac_out[16*k +: 16]);
   endfunction

   task automatic set_lanes(input int a, input int b, input int c, input int d);
      int v[4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int k = 0; k < N; k++) dac_in[16*k +: 16] = 16'(v[k % 4]);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   int exp_cnt;

   initial begin
      reset = 1'b1; enable = 1'b0; ramp_step = '0; gain_shift = '0;
      set_lanes(1000, 1000, 1000, 1000);
      repeat (3) tick();
      chk("reset g", ramp_gain, 0);
      chk("reset state", state, 0);
      chk("reset dac_out", dac_out, 0);
      reset = 1'b0;

      // Idle with input present stays muted.
      repeat (5) tick();
      chk("idle g", ramp_gain, 0);
      chk("idle dac_out lane0", lane(0), 0);

      // Ramp up 8192 per clock on a 16384 input.
      ramp_step = 16'd8192; enable = 1'b1; set_lanes(16384, 16384, 16384, 16384);
      tick(); chk("up g1", ramp_gain, 8192); chk("up state1", state, 1);
      tick(); chk("up g2", ramp_gain, 16384);
      tick(); chk("up g3", ramp_gain, 24576); chk("up out3", lane(0), 4096);
      tick(); chk("up g4", ramp_gain, 32768); chk("up state4", state, 2);
      chk("up done4", ramp_done, 1); chk("up out4", lane(5), 8192);
      tick(); chk("up done5", ramp_done, 0); chk("up out5", lane(3), 12288);
      tick(); chk("up out6", lane(7), 16384);

      // Ramp down 10000 per clock with a reversal at 12768.
      ramp_step = 16'd10000; enable = 1'b0;
      tick(); chk("dn g1", ramp_gain, 22768); chk("dn state1", state, 3);
      tick(); chk("dn g2", ramp_gain, 12768);
      enable = 1'b1;
      tick(); chk("rev g", ramp_gain, 12768); chk("rev state", state, 1); chk("rev done", ramp_done, 0);
      tick(); chk("rev up g", ramp_gain, 22768);
      enable = 1'b0;
      tick(); chk("rev2 g", ramp_gain, 22768); chk("rev2 state", state, 3);
      tick(); chk("dn g3", ramp_gain, 12768);
      tick(); chk("dn g4", ramp_gain, 2768);
      tick(); chk("dn g5", ramp_gain, 0); chk("dn state5", state, 0); chk("dn done5", ramp_done, 1);

      // Zero step jumps in one clock each way.
      ramp_step = 16'd0; enable = 1'b1;
      tick(); chk("jump up g", ramp_gain, 32768); chk("jump up state", state, 2); chk("jump up done", ramp_done, 1);
      enable = 1'b0;
      tick(); chk("jump dn g", ramp_gain, 0); chk("jump dn state", state, 0); chk("jump dn done", ramp_done, 1);
      enable = 1'b1;
      tick(); chk("jump up2 state", state, 2);

      // Boost x8 with saturation.
      gain_shift = 2'd3; set_lanes(5000, -5000, 4095, -4096);
      exp_cnt = clip_count;
      tick(); tick();
      chk("sat lane0", lane(0), 32767);
      chk("sat lane1", lane(1), -32768);
      chk("sat lane2", lane(2), 32760);
      chk("sat lane7", lane(7), -32768);
`ifdef DAC_SOFT_MUTE_CLIP_COUNT_EN
      exp_cnt = exp_cnt + 1;
`endif
      chk("clip cnt a", clip_count, exp_cnt);
      tick();
`ifdef DAC_SOFT_MUTE_CLIP_COUNT_EN
      exp_cnt = exp_cnt + 1;
`endif
      chk("clip cnt b", clip_count, exp_cnt);

      // Unity gain, no boost: full-scale pass-through.
      gain_shift = 2'd0; set_lanes(32767, -32768, 1, -1);
      tick(); tick();
      chk("pass lane0", lane(0), 32767);
      chk("pass lane1", lane(1), -32768);
      chk("pass lane3", lane(3), -1);

      // Half gain held by toggling enable; checks round-half-up.
      ramp_step = 16'd8192; enable = 1'b0;
      tick(); tick(); chk("half g", ramp_gain, 16384);
      enable = 1'b1; set_lanes(1, -1, 3, -3);
      tick(); chk("hold g1", ramp_gain, 16384);
      enable = 1'b0; tick();
      enable = 1'b1; tick();
      chk("hold g3", ramp_gain, 16384); chk("hold state", state, 1);
      chk("rnd lane0", lane(0), 1);
      chk("rnd lane1", lane(1), 0);
      chk("rnd lane2", lane(2), 2);
      chk("rnd lane3", lane(3), -1);

      // Asynchronous reset mid-ramp.
      #2 reset = 1'b1;
      #1;
      chk("async g", ramp_gain, 0);
      chk("async state", state, 0);
      chk("async dac_out", dac_out, 0);
      chk("async clip", clip_count, 0);
      tick(); tick();
      reset = 1'b0; enable = 1'b0;
      tick();

      // Maximum step: no wrap in the 18-bit arithmetic.
      ramp_step = 16'hFFFF; enable = 1'b1; set_lanes(-12345, 777, 0, 32767);
      tick(); chk("max up g", ramp_gain, 32768); chk("max up state", state, 2);
      tick(); tick();
      chk("max pass lane0", lane(0), -12345);
      enable = 1'b0;
      tick(); chk("max dn g", ramp_gain, 0); chk("max dn done", ramp_done, 1);
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
